xalu_seq: RTL and testbench
===========================

# xalu_seq

Parametrised, registered successor of the 4-bit combinational ALU slice. It runs the same eight function codes over a `WIDTH`-bit datapath and adds three multi-cycle operations: left shift by N, right shift by N, and unsigned multiply. Operands enter through a valid/ready input handshake and results leave through a valid/ready output handshake, so the block sits between a register file or sequencer and its writeback path. The ones'-complement output mode and the ZERO, NEG_ZERO and EQU status outputs are kept, registered alongside the result.

## Interface
- `WIDTH`, default 8: datapath width. Minimum 4.
- `SW`, default `$clog2(WIDTH)`: shift-amount width. Derived; do not override.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operand/op presented.
- `in_ready` out 1: block accepts this cycle.
- `op` in 4: function code; see Operation.
- `com` in 1: ones'-complement the result.
- `a`, `b` in WIDTH: operands.
- `ci_left`, `ci_right` in 1: carry/fill inputs.
- `out_valid` out 1: result registers valid.
- `out_ready` in 1: consumer takes the result.
- `y` out WIDTH: result.
- `co_left`, `co_right` out 1: carry outputs.
- `equ` out 1: captured `a == b`.
- `zero` out 1: `y` is all 0s.
- `neg_zero` out 1: `y` is all 1s.
- `busy` out 1: FSM is in EXEC.

## Operation
- **Accept:** `in_valid & in_ready` captures `op`, `com`, `a`, `b`, `ci_left` and `ci_right`. Inputs are ignored at all other times.
- **Single-cycle opcodes:**
  - 0 ADD: `a+b+ci_right`; `co_left` = carry out of the MSB.
  - 1 AND.
  - 2 OR.
  - 3 XOR.
  - 4 PASSA.
  - 5 PASSB.
  - 6 SHR by 1: `ci_left` fills the MSB; `co_right` = `a[0]`.
  - 7 SHL by 1: `ci_right` fills the LSB; `co_left` = `a[WIDTH-1]`.
- **Multi-cycle opcodes:**
  - 8 SHLN: shift `a` left by `n = b[SW-1:0]`, one bit per cycle. `ci_right` fills every vacated bit. `co_left` = last bit shifted out, or 0 if n=0.
  - 9 SHRN: mirror of SHLN. `ci_left` fills; `co_right` = last bit shifted out.
  - 10 MUL: unsigned shift-add multiply, one bit of `b` per cycle. `y` = low WIDTH bits of the product. `co_left` = OR of the high WIDTH bits (overflow).
- **Reserved opcodes 11–15:** single-cycle; `y` = 0 and both carries 0.
- **Carries:** any carry output not defined for an opcode is 0.
- **Complement:** `y` = `com ? ~r : r`, where `r` is the raw result.
- **Flags:** `zero` and `neg_zero` are evaluated on the final `y`, after complement. `equ` is evaluated on the captured operands.
- **FSM states:**
  - IDLE → LOAD: on accept of a single-cycle op, or of SHLN/SHRN with n=0.
  - IDLE → EXEC: on accept of SHLN/SHRN with n>0, or of MUL. EXEC holds a down-counter set to n (shifts) or WIDTH (MUL).
  - EXEC → DONE: when the counter reaches 1; that cycle writes the result registers.
  - DONE → IDLE: on `out_ready` with no new accept.
  - DONE → DONE or EXEC: on `out_ready` together with a same-cycle accept.
  - LOAD is implicit: results are written on the accept edge, and the FSM enters DONE directly.
- **`in_ready`:** `!rst & (IDLE | (DONE & out_ready))`.
- **`busy`:** high exactly in EXEC.

## Timing
- **Latency:** for an accept at edge t, `out_valid` rises after edge t+1 for single-cycle ops and for shifts with n=0. It rises after edge t+n+1 for SHLN/SHRN and after edge t+WIDTH+1 for MUL.
- **Throughput:** one single-cycle op per clock when `out_ready` is held high.
- **Output stability:** `y`, the carries and the flags are registered and held stable while `out_valid & !out_ready`. `out_valid` never drops without a handshake.
- **Reset values:** `out_valid` = 0, `y` = 0, `co_left` = `co_right` = 0, `equ` = `zero` = `neg_zero` = 0, `busy` = 0, FSM in IDLE.
- **Reset during EXEC or DONE:** the operation is abandoned; its result is never presented.
- **Stale operands:** if `a`, `b` or `op` change during EXEC, there is no effect; only the captured copies are used.

## Structure
- **Package `xalu_pkg`:** the `op_e` enum (4-bit, values 0–10 as named above), the `state_e` enum (IDLE, EXEC, DONE) and a helper function `is_multi(op)`.
- **Sub-module `xalu_comb`:** purely combinational, WIDTH-parametrised single-cycle function unit for opcodes 0–7 plus the reserved codes. It returns `r`, `co_left` and `co_right`.
- **Top level:** owns the FSM, the counter, the shift/multiply accumulators, the complement stage and the flag registers.

## Test plan
All scenarios use WIDTH=8.
- ADD: `a`=0xF0, `b`=0x20, `ci_right`=1, `com`=0 → `y`=0x11, `co_left`=1, `zero`=0; `out_valid` one cycle after accept.
- SHLN: `a`=0x81, `b`=3, `ci_right`=1 → `busy` high for 3 cycles, `y`=0x0F, `co_left`=0, `out_valid` 4 cycles after accept. Repeat with `b`=0 → `y`=0x81, `co_left`=0, latency 1.
- MUL: `a`=0x10, `b`=0x11 → `y`=0x10, `co_left`=1, latency 9. Repeat with `a`=0x0F, `b`=0x0F → `y`=0xE1, `co_left`=0.
- XOR: `a`=`b`=0x5A, `com`=1 → `y`=0xFF, `neg_zero`=1, `zero`=0, `equ`=1.
- Backpressure: hold `out_ready`=0 for 3 cycles after `out_valid` → `y` and flags stable and `in_ready`=0. Then raise `out_ready` with the next op already valid → handshake and accept in the same cycle, next result one cycle later.
- Reset: assert `rst` 4 cycles into a MUL → after the next edge `out_valid`=0, `busy`=0, all outputs 0, and that MUL result never appears.

Source files
------------

// File: rtl/xalu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, and the multi-cycle opcode test.
package xalu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_AND   = 4'd1,
    OP_OR    = 4'd2,
    OP_XOR   = 4'd3,
    OP_PASSA = 4'd4,
    OP_PASSB = 4'd5,
    OP_SHR   = 4'd6,
    OP_SHL   = 4'd7,
    OP_SHLN  = 4'd8,
    OP_SHRN  = 4'd9,
    OP_MUL   = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // True for opcodes that iterate in the EXEC state.
  function automatic logic is_multi(input logic [OP_W-1:0] op);
    return (op == OP_SHLN) || (op == OP_SHRN) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/xalu_seq_if.sv
// Operand/result handshake bundle for xalu_seq.
// master: producer of operands and consumer of results (sequencer side).
// slave : the ALU itself.
interface xalu_seq_if #(parameter int unsigned WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic             com;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci_left;
  logic             ci_right;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             co_left;
  logic             co_right;
  logic             equ;
  logic             zero;
  logic             neg_zero;
  logic             busy;

  modport master (
    output in_valid, op, com, a, b, ci_left, ci_right, out_ready,
    input  in_ready, out_valid, y, co_left, co_right, equ, zero, neg_zero, busy
  );

  modport slave (
    input  in_valid, op, com, a, b, ci_left, ci_right, out_ready,
    output in_ready, out_valid, y, co_left, co_right, equ, zero, neg_zero, busy
  );

endinterface

// File: rtl/xalu_comb.sv
// Combinational single-cycle function unit (opcodes 0-7; everything else yields 0).
// Ports: op, a, b, ci_left, ci_right in; raw result r and carries co_left/co_right out.
module xalu_comb
  import xalu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci_left,
  input  logic             ci_right,
  output logic [WIDTH-1:0] r,
  output logic             co_left,
  output logic             co_right
);

  logic [WIDTH:0] sum;

  always_comb begin
    r        = '0;
    co_left  = 1'b0;
    co_right = 1'b0;
    sum      = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(ci_right);
    case (op_e'(op))
      OP_ADD:   begin r = sum[WIDTH-1:0]; co_left = sum[WIDTH]; end
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      OP_SHR:   begin r = {ci_left, a[WIDTH-1:1]}; co_right = a[0]; end
      OP_SHL:   begin r = {a[WIDTH-2:0], ci_right}; co_left = a[WIDTH-1]; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/xalu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and multi-cycle
// shift-by-N and shift-add multiply.
// Ports: clk, rst (sync, active-high); io (xalu_seq_if.slave) carries the
// operand handshake, the result handshake, the result/carry/flag outputs and busy.
module xalu_seq
  import xalu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SW    = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  xalu_seq_if.slave  io
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic             com_q, com_d;
  logic             fill_q, fill_d;
  logic             equ_cap_q, equ_cap_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             co_left_q, co_left_d;
  logic             co_right_q, co_right_d;
  logic             equ_q, equ_d;
  logic             zero_q, zero_d;
  logic             neg_zero_q, neg_zero_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] comb_r;
  logic             comb_cl, comb_cr;
  logic             accept;
  logic [CW-1:0]    shift_n;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             step_c;
  logic             write_res;
  logic [WIDTH-1:0] res_r, y_fin;
  logic             res_cl, res_cr, res_com, res_equ;

  xalu_comb #(.WIDTH(WIDTH)) u_comb (
    .op       (io.op),
    .a        (io.a),
    .b        (io.b),
    .ci_left  (io.ci_left),
    .ci_right (io.ci_right),
    .r        (comb_r),
    .co_left  (comb_cl),
    .co_right (comb_cr)
  );

  assign io.in_ready = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && io.out_ready));
  assign accept      = io.in_valid && io.in_ready;
  assign shift_n     = CW'(io.b[SW-1:0]);

  // Next-state, datapath iteration and result capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    com_d      = com_q;
    fill_d     = fill_q;
    equ_cap_d  = equ_cap_q;
    a_d        = a_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    y_d        = y_q;
    co_left_d  = co_left_q;
    co_right_d = co_right_q;
    equ_d      = equ_q;
    zero_d     = zero_q;
    neg_zero_d = neg_zero_q;
    write_res  = 1'b0;
    res_r      = '0;
    res_cl     = 1'b0;
    res_cr     = 1'b0;
    res_com    = 1'b0;
    res_equ    = 1'b0;

    // One iteration step: lo_q is the shift register / multiplier, hi_q the partial product.
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    step_hi = hi_q;
    step_lo = lo_q;
    step_c  = 1'b0;
    case (op_q)
      OP_SHLN: begin step_lo = {lo_q[WIDTH-2:0], fill_q}; step_c = lo_q[WIDTH-1]; end
      OP_SHRN: begin step_lo = {fill_q, lo_q[WIDTH-1:1]}; step_c = lo_q[0]; end
      OP_MUL:  begin step_hi = mul_sum[WIDTH:1]; step_lo = {mul_sum[0], lo_q[WIDTH-1:1]}; end
      default: ;
    endcase

    case (state_q)
      S_EXEC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          write_res = 1'b1;
          res_r     = step_lo;
          res_cl    = (op_q == OP_SHLN) ? step_c : ((op_q == OP_MUL) ? |step_hi : 1'b0);
          res_cr    = (op_q == OP_SHRN) && step_c;
          res_com   = com_q;
          res_equ   = equ_cap_q;
          state_d   = S_DONE;
        end
      end
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && io.out_ready) state_d = S_IDLE;
        if (accept) begin
          op_d      = op_e'(io.op);
          com_d     = io.com;
          equ_cap_d = (io.a == io.b);
          a_d       = io.a;
          // Zero-length shifts complete immediately with a pass-through result.
          if (is_multi(io.op) && !((io.op != OP_MUL) && (shift_n == '0))) begin
            state_d = S_EXEC;
            hi_d    = '0;
            lo_d    = (io.op == OP_MUL) ? io.b : io.a;
            fill_d  = (io.op == OP_SHLN) ? io.ci_right : io.ci_left;
            cnt_d   = (io.op == OP_MUL) ? CW'(WIDTH) : shift_n;
          end else begin
            write_res = 1'b1;
            res_r     = is_multi(io.op) ? io.a : comb_r;
            res_cl    = !is_multi(io.op) && comb_cl;
            res_cr    = !is_multi(io.op) && comb_cr;
            res_com   = io.com;
            res_equ   = (io.a == io.b);
            state_d   = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Complement stage and flags on the final value.
    y_fin = res_com ? ~res_r : res_r;
    if (write_res) begin
      y_d        = y_fin;
      co_left_d  = res_cl;
      co_right_d = res_cr;
      equ_d      = res_equ;
      zero_d     = (y_fin == '0);
      neg_zero_d = &y_fin;
    end

    busy_d      = (state_d == S_EXEC);
    out_valid_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_ADD;
      com_q       <= 1'b0;
      fill_q      <= 1'b0;
      equ_cap_q   <= 1'b0;
      a_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      y_q         <= '0;
      co_left_q   <= 1'b0;
      co_right_q  <= 1'b0;
      equ_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      com_q       <= com_d;
      fill_q      <= fill_d;
      equ_cap_q   <= equ_cap_d;
      a_q         <= a_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      y_q         <= y_d;
      co_left_q   <= co_left_d;
      co_right_q  <= co_right_d;
      equ_q       <= equ_d;
      zero_q      <= zero_d;
      neg_zero_q  <= neg_zero_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.y         = y_q;
  assign io.co_left   = co_left_q;
  assign io.co_right  = co_right_q;
  assign io.equ       = equ_q;
  assign io.zero      = zero_q;
  assign io.neg_zero  = neg_zero_q;
  assign io.busy      = busy_q;

endmodule

// File: tb/tb_xalu_seq.sv
// Self-checking bench for xalu_seq (WIDTH=8): directed scenarios plus
// randomized ops checked against an arithmetic reference model.
module tb_xalu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  xalu_seq_if #(.WIDTH(8)) bus ();

  xalu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: result straight from the arithmetic definition of each opcode.
  task automatic model(input logic [3:0] op, input logic com, input logic [7:0] a, input logic [7:0] b,
                       input logic cil, input logic cir,
                       output logic [7:0] y, output logic cl, output logic cr,
                       output logic eq, output logic z, output logic nz, output int lat);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r;
    logic [7:0]  m;
    int          n;
    r = 8'h00; cl = 1'b0; cr = 1'b0; lat = 1;
    n = int'(b[2:0]);
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b} + 9'(cir); r = s[7:0]; cl = s[8]; end
      4'd1: r = a & b;
      4'd2: r = a | b;
      4'd3: r = a ^ b;
      4'd4: r = a;
      4'd5: r = b;
      4'd6: begin r = {cil, a[7:1]}; cr = a[0]; end
      4'd7: begin r = {a[6:0], cir}; cl = a[7]; end
      4'd8: begin
        r = 8'(a << n);
        if (cir) r = r | 8'((1 << n) - 1);
        if (n > 0) begin cl = a[8-n]; lat = n + 1; end
      end
      4'd9: begin
        m = 8'hFF;
        m = m >> n;
        r = a >> n;
        if (cil) r = r | ~m;
        if (n > 0) begin cr = a[n-1]; lat = n + 1; end
      end
      4'd10: begin p = 16'(a) * 16'(b); r = p[7:0]; cl = |p[15:8]; lat = 9; end
      default: ;
    endcase
    y  = com ? ~r : r;
    eq = (a == b);
    z  = (y == 8'h00);
    nz = (y == 8'hFF);
  endtask

  // Present one op, wait (bounded) for out_valid; lat = -1 on timeout. out_ready stays low.
  task automatic run_op(input logic [3:0] op, input logic com, input logic [7:0] a, input logic [7:0] b,
                        input logic cil, input logic cir, output int lat, output int bcyc);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = op; bus.com = com; bus.a = a; bus.b = b;
    bus.ci_left = cil; bus.ci_right = cir; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.op = 4'($urandom); bus.com = 1'($urandom);
    lat = 1; bcyc = 0;
    while (!bus.out_valid && lat < 64) begin
      if (bus.busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.y !== 8'h00) begin errors++; $display("FAIL reset_y got=%h exp=00", bus.y); end
    checks++; if ({bus.co_left, bus.co_right, bus.equ, bus.zero, bus.neg_zero, bus.busy} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=000000", {bus.co_left, bus.co_right, bus.equ, bus.zero, bus.neg_zero, bus.busy}); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_add();
    int lat, bc;
    run_op(4'd0, 1'b0, 8'hF0, 8'h20, 1'b0, 1'b1, lat, bc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
    checks++; if (bus.y !== 8'h11) begin errors++; $display("FAIL add_y got=%h exp=11", bus.y); end
    checks++; if (bus.co_left !== 1'b1 || bus.zero !== 1'b0) begin
      errors++; $display("FAIL add_co_zero got=%b%b exp=10", bus.co_left, bus.zero); end
    consume();
  endtask

  task automatic test_shln();
    int lat, bc;
    run_op(4'd8, 1'b0, 8'h81, 8'h03, 1'b0, 1'b1, lat, bc);
    checks++; if (lat !== 4) begin errors++; $display("FAIL shln_latency got=%0d exp=4", lat); end
    checks++; if (bc !== 3) begin errors++; $display("FAIL shln_busy_cycles got=%0d exp=3", bc); end
    checks++; if (bus.y !== 8'h0F || bus.co_left !== 1'b0) begin
      errors++; $display("FAIL shln_result got=%h/%b exp=0f/0", bus.y, bus.co_left); end
    consume();
    run_op(4'd8, 1'b0, 8'h81, 8'h00, 1'b0, 1'b1, lat, bc);
    checks++; if (lat !== 1 || bc !== 0) begin errors++; $display("FAIL shln0_latency got=%0d/%0d exp=1/0", lat, bc); end
    checks++; if (bus.y !== 8'h81 || bus.co_left !== 1'b0) begin
      errors++; $display("FAIL shln0_result got=%h/%b exp=81/0", bus.y, bus.co_left); end
    consume();
  endtask

  task automatic test_mul();
    int lat, bc;
    run_op(4'd10, 1'b0, 8'h10, 8'h11, 1'b0, 1'b0, lat, bc);
    checks++; if (lat !== 9) begin errors++; $display("FAIL mul_latency got=%0d exp=9", lat); end
    checks++; if (bus.y !== 8'h10 || bus.co_left !== 1'b1) begin
      errors++; $display("FAIL mul_ovf got=%h/%b exp=10/1", bus.y, bus.co_left); end
    consume();
    run_op(4'd10, 1'b0, 8'h0F, 8'h0F, 1'b0, 1'b0, lat, bc);
    checks++; if (bus.y !== 8'hE1 || bus.co_left !== 1'b0) begin
      errors++; $display("FAIL mul_noovf got=%h/%b exp=e1/0", bus.y, bus.co_left); end
    consume();
  endtask

  task automatic test_xor();
    int lat, bc;
    run_op(4'd3, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b0, lat, bc);
    checks++; if (bus.y !== 8'hFF) begin errors++; $display("FAIL xor_com_y got=%h exp=ff", bus.y); end
    checks++; if ({bus.neg_zero, bus.zero, bus.equ} !== 3'b101) begin
      errors++; $display("FAIL xor_flags got=%b exp=101", {bus.neg_zero, bus.zero, bus.equ}); end
    consume();
    run_op(4'd3, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b0, lat, bc);
  endtask

  task automatic test_reset_mid_mul();
    bit seen = 1'b0;
    consume();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'd10; bus.com = 1'b0; bus.a = 8'hFF; bus.b = 8'hFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_mul_state got=%b%b exp=00", bus.out_valid, bus.busy); end
    checks++; if ({bus.y, bus.co_left, bus.co_right, bus.equ, bus.zero, bus.neg_zero} !== 13'h0) begin
      errors++; $display("FAIL rst_mul_outputs got=%h exp=0", {bus.y, bus.co_left, bus.co_right, bus.equ, bus.zero, bus.neg_zero}); end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mul_abandoned got=%b exp=0", seen); end
  endtask

  task automatic test_backpressure();
    int lat, bc;
    run_op(4'd0, 1'b0, 8'h33, 8'h44, 1'b0, 1'b0, lat, bc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.y !== 8'h77 || bus.zero !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle=%0d got=v%b y=%h z=%b rdy=%b exp=v1 y=77 z=0 rdy=0",
                           i, bus.out_valid, bus.y, bus.zero, bus.in_ready); end
    end
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'd3; bus.com = 1'b0; bus.a = 8'h0F; bus.b = 8'hF0;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.y !== 8'hFF || bus.neg_zero !== 1'b1) begin
      errors++; $display("FAIL bp_next got=v%b y=%h nz=%b exp=v1 y=ff nz=1", bus.out_valid, bus.y, bus.neg_zero); end
    consume();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic       com, cil, cir;
    logic [7:0] a, b, ey;
    logic       ecl, ecr, eeq, ez, enz;
    int         elat, lat, bc;
    for (int i = 0; i < 40; i++) begin
      op  = 4'($urandom_range(0, 15));
      com = 1'($urandom);
      a   = 8'($urandom);
      b   = (i % 5 == 0) ? a : 8'($urandom);
      cil = 1'($urandom);
      cir = 1'($urandom);
      model(op, com, a, b, cil, cir, ey, ecl, ecr, eeq, ez, enz, elat);
      run_op(op, com, a, b, cil, cir, lat, bc);
      checks++; if (lat !== elat || bc !== elat - 1) begin
        errors++; $display("FAIL rnd_latency op=%0d got=%0d/%0d exp=%0d/%0d", op, lat, bc, elat, elat - 1); end
      checks++; if (bus.y !== ey) begin
        errors++; $display("FAIL rnd_y op=%0d a=%h b=%h com=%b got=%h exp=%h", op, a, b, com, bus.y, ey); end
      checks++; if ({bus.co_left, bus.co_right} !== {ecl, ecr}) begin
        errors++; $display("FAIL rnd_carry op=%0d a=%h b=%h got=%b%b exp=%b%b", op, a, b, bus.co_left, bus.co_right, ecl, ecr); end
      checks++; if ({bus.equ, bus.zero, bus.neg_zero} !== {eeq, ez, enz}) begin
        errors++; $display("FAIL rnd_flags op=%0d got=%b%b%b exp=%b%b%b", op, bus.equ, bus.zero, bus.neg_zero, eeq, ez, enz); end
      consume();
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.op = 4'd0; bus.com = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
    bus.ci_left = 1'b0; bus.ci_right = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_shln();
    test_mul();
    test_xor();
    test_reset_mid_mul();
    test_backpressure();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
